xbuf_seq_ctrl: RTL and testbench

// Sequencer for the X operand buffer of the matrix unit. Per matrix row it drives a LOAD phase
// (accepts LOAD_WORDS input beats into the buffer), then a COMPUTE phase (SHIFT_STEPS rotate

---
 rtl/matpu_pkg.sv | 32 +++
 rtl/xbuf_seq_ctrl_if.sv | 34 +++
 rtl/xbuf_seq_ctrl_step_cnt.sv | 51 +++++
 rtl/xbuf_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_xbuf_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/matpu_pkg.sv
// Shared matrix-unit definitions: sequencer state type, default X-buffer
// geometry and counter widths used by the sequencer and the X buffer.
package matpu_pkg;

    localparam int unsigned XBUF_LOAD_WORDS  = 7;
    localparam int unsigned XBUF_SHIFT_STEPS = 9;
    localparam int unsigned XSEQ_DRAIN_CYC   = 4;

    localparam int unsigned COL_W   = 8;
    localparam int unsigned SHIFT_W = 4;
    localparam int unsigned ACC_W   = 8;
    localparam int unsigned ROWS_W  = 8;
    localparam int unsigned DRAIN_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_DONE
    } xseq_state_t;

    // Legal sequencer geometry: counters must never need to wrap past their width.
    function automatic logic xseq_params_ok(input int unsigned load_words,
                                            input int unsigned shift_steps,
                                            input int unsigned drain_cyc);
        return (load_words >= 1) && (load_words <= 256) &&
               (shift_steps >= 1) && (shift_steps <= 16) &&
               (drain_cyc >= 1) && (drain_cyc <= 65536);
    endfunction

endpackage

// File: rtl/xbuf_seq_ctrl_if.sv
// Control/handshake bundle between the APB data path, the X-buffer
// sequencer and the X buffer / MAC array.
interface xbuf_seq_ctrl_if;
    import matpu_pkg::*;

    logic               start;
    logic               abort;
    logic [ROWS_W-1:0]  cfg_rows;
    logic               in_valid;
    logic               in_ready;
    logic               mac_ready;
    logic               load_en;
    logic               x_shift;
    logic [COL_W-1:0]   col_counter;
    logic [SHIFT_W-1:0] shift_count;
    logic [ACC_W-1:0]   acc_counter;
    logic               busy;
    logic               done;

    // Requesting side (register block / data path / MAC array model).
    modport master (
        output start, abort, cfg_rows, in_valid, mac_ready,
        input  in_ready, load_en, x_shift, col_counter, shift_count,
               acc_counter, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, abort, cfg_rows, in_valid, mac_ready,
        output in_ready, load_en, x_shift, col_counter, shift_count,
               acc_counter, busy, done
    );

endinterface

// File: rtl/xbuf_seq_ctrl_step_cnt.sv
// Step counter: counts 0..term_i on enable, synchronous clear has priority.
// At the terminal value it either wraps to 0 (WRAP=1) or holds (WRAP=0);
// wrap_o flags the enabled step taken at the terminal value.
module xseq_step_cnt #(
    parameter int unsigned WIDTH = 8,
    parameter bit          WRAP  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] term_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear, step, or wrap/hold at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (last_o) begin
                cnt_d = WRAP ? '0 : cnt_q;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    // Count register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal compare and wrap flag.
    always_comb begin
        last_o = (cnt_q == term_i);
        wrap_o = en_i & last_o & ~clr_i;
        cnt_o  = cnt_q;
    end

endmodule

// File: rtl/xbuf_seq_ctrl.sv
// X operand buffer sequencer: per row a LOAD phase of LOAD_WORDS beats and a
// COMPUTE phase of SHIFT_STEPS MAC-paced rotates, then DRAIN and a DONE pulse.
module xbuf_seq_ctrl
    import matpu_pkg::*;
#(
    parameter int unsigned LOAD_WORDS  = XBUF_LOAD_WORDS,
    parameter int unsigned SHIFT_STEPS = XBUF_SHIFT_STEPS,
    parameter int unsigned DRAIN_CYC   = XSEQ_DRAIN_CYC
) (
    input  logic          clk,
    input  logic          rst,
    xbuf_seq_ctrl_if.slave bus
);

    if (!xseq_params_ok(LOAD_WORDS, SHIFT_STEPS, DRAIN_CYC)) begin : g_bad_params
        $error("xbuf_seq_ctrl: LOAD_WORDS, SHIFT_STEPS or DRAIN_CYC out of range");
    end

    localparam logic [COL_W-1:0]   COL_TERM   = COL_W'(LOAD_WORDS - 1);
    localparam logic [SHIFT_W-1:0] SHIFT_TERM = SHIFT_W'(SHIFT_STEPS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_TERM = DRAIN_W'(DRAIN_CYC - 1);

    xseq_state_t        state_q;
    logic [ROWS_W-1:0]  rows_q;
    logic [ACC_W-1:0]   acc_q;

    logic               in_load;
    logic               in_compute;
    logic               in_drain;
    logic               start_ok;
    logic               beat;
    logic               step;
    logic               last_row;
    logic               row_next;
    logic               col_clr;
    logic               shift_clr;
    logic               drain_clr;
    logic               drain_en;

    logic [COL_W-1:0]   col_cnt;
    logic               col_last_unused;
    logic               col_wrap;
    logic [SHIFT_W-1:0] shift_cnt;
    logic               shift_last_unused;
    logic               shift_wrap;
    logic [DRAIN_W-1:0] drain_cnt_unused;
    logic               drain_last_unused;
    logic               drain_wrap;

    // Handshake qualification; abort suppresses every accept/step in its cycle.
    always_comb begin
        in_load    = (state_q == ST_LOAD);
        in_compute = (state_q == ST_COMPUTE);
        in_drain   = (state_q == ST_DRAIN);
        start_ok   = (state_q == ST_IDLE) & bus.start & (bus.cfg_rows != '0) & ~bus.abort;
        beat       = in_load & bus.in_valid & ~bus.abort;
        step       = in_compute & bus.mac_ready & ~bus.abort;
        last_row   = (acc_q == ACC_W'(rows_q - ROWS_W'(1)));
        row_next   = shift_wrap & ~last_row;
        col_clr    = bus.abort | start_ok | row_next;
        shift_clr  = bus.abort | start_ok;
        // Drain counter idles at 0 outside DRAIN, so entry always starts a full wait.
        drain_clr  = ~in_drain | bus.abort;
        drain_en   = in_drain & ~bus.abort;
    end

    xseq_step_cnt #(.WIDTH(COL_W), .WRAP(1'b0)) u_col_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (col_clr),
        .en_i   (beat),
        .term_i (COL_TERM),
        .cnt_o  (col_cnt),
        .last_o (col_last_unused),
        .wrap_o (col_wrap)
    );

    xseq_step_cnt #(.WIDTH(SHIFT_W), .WRAP(1'b1)) u_shift_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (shift_clr),
        .en_i   (step),
        .term_i (SHIFT_TERM),
        .cnt_o  (shift_cnt),
        .last_o (shift_last_unused),
        .wrap_o (shift_wrap)
    );

    // Counts up 0..DRAIN_CYC-1; same cycle count as loading DRAIN_CYC-1 and counting down.
    xseq_step_cnt #(.WIDTH(DRAIN_W), .WRAP(1'b0)) u_drain_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (drain_clr),
        .en_i   (drain_en),
        .term_i (DRAIN_TERM),
        .cnt_o  (drain_cnt_unused),
        .last_o (drain_last_unused),
        .wrap_o (drain_wrap)
    );

    // Sequencer FSM with row bookkeeping; abort overrides every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            rows_q  <= '0;
            acc_q   <= '0;
        end else if (bus.abort) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q <= ST_LOAD;
                        rows_q  <= bus.cfg_rows;
                        acc_q   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (col_wrap) begin
                        state_q <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (shift_wrap) begin
                        if (last_row) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_LOAD;
                            acc_q   <= acc_q + ACC_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_wrap) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state and counters.
    always_comb begin
        bus.load_en     = in_load;
        bus.in_ready    = in_load & ~bus.abort;
        bus.x_shift     = step;
        bus.busy        = (state_q != ST_IDLE);
        bus.done        = (state_q == ST_DONE);
        bus.col_counter = col_cnt;
        bus.shift_count = shift_cnt;
        bus.acc_counter = acc_q;
    end

endmodule

// File: tb/tb_xbuf_seq_ctrl.sv
// Directed self-checking bench for xbuf_seq_ctrl (LOAD_WORDS=7, SHIFT_STEPS=9, DRAIN_CYC=4).
module tb_xbuf_seq_ctrl;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    xbuf_seq_ctrl_if bus ();

    xbuf_seq_ctrl #(.LOAD_WORDS(7), .SHIFT_STEPS(9), .DRAIN_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int beats;
        int shifts;
        int done_at;
        int dones;
        int busy_cyc;
        int busy_after;
        int loads;
        int first_load;
        int seq_err;
        int gate_err;
        int hold_err;
        int acc_done;
        int col_done;
        int sh_done;
    } stats_t;

    // Runs one job from a start pulse and gathers observations (no judging here).
    task automatic run_job(input int rows, input bit rnd, input bit poke, output stats_t s);
        bit prev_load, prev_beat, prev_xs, prev_busy, beat;
        int prev_col, prev_sh;
        s = '{default: 0};
        s.done_at = -1; s.busy_after = 1; s.first_load = -1;
        prev_load = 0; prev_beat = 0; prev_xs = 0; prev_busy = 0; prev_col = 0; prev_sh = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_rows = 8'(rows); bus.in_valid = 1'b1; bus.mac_ready = 1'b1;
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (rnd) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.mac_ready = 1'($urandom_range(0, 1));
            end
            if (poke && c == 12) begin
                bus.start = 1'b1; bus.cfg_rows = 8'd5;
            end
            #1;
            beat = bus.in_valid && bus.in_ready;
            if (beat) begin
                if (int'(bus.col_counter) != s.beats % 7) s.seq_err++;
                if (int'(bus.acc_counter) != s.beats / 7) s.seq_err++;
                s.beats++;
            end
            if (bus.x_shift) begin
                if (int'(bus.shift_count) != s.shifts % 9) s.seq_err++;
                s.shifts++;
            end
            if (bus.x_shift && !bus.mac_ready) s.gate_err++;
            if (bus.in_ready && !bus.load_en) s.gate_err++;
            if (prev_load && !prev_beat && bus.load_en && int'(bus.col_counter) != prev_col) s.hold_err++;
            if (prev_busy && bus.busy && !prev_xs && int'(bus.shift_count) != prev_sh) s.hold_err++;
            if (bus.load_en && !prev_load) begin
                s.loads++;
                if (s.first_load < 0) s.first_load = c;
                if (bus.col_counter != 8'd0) s.seq_err++;
            end
            if (bus.busy) s.busy_cyc++;
            if (bus.done) begin
                s.dones++; s.done_at = c;
                s.acc_done = int'(bus.acc_counter);
                s.col_done = int'(bus.col_counter);
                s.sh_done  = int'(bus.shift_count);
            end
            if (s.dones != 0 && c == s.done_at + 1) s.busy_after = int'(bus.busy);
            if (s.dones != 0 && c >= s.done_at + 3) break;
            prev_load = bus.load_en; prev_beat = beat; prev_xs = bus.x_shift;
            prev_busy = bus.busy; prev_col = int'(bus.col_counter); prev_sh = int'(bus.shift_count);
        end
        bus.in_valid = 1'b0; bus.mac_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [30:0] obs;
        rst = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_rows = 8'd0;
        bus.in_valid = 1'b1; bus.mac_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        obs = {bus.in_ready, bus.load_en, bus.x_shift, bus.busy, bus.done,
               bus.col_counter, bus.shift_count, bus.acc_counter, 2'b00};
        total++; if (obs !== 31'd0) $display("FAIL reset_outputs: got %h expected 0", obs); else passed++;
        bus.in_valid = 1'b0; bus.mac_ready = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_single_row();
        stats_t s;
        run_job(1, 1'b0, 1'b0, s);
        total++; if (s.first_load !== 1) $display("FAIL one_row_load_latency: got %0d expected 1", s.first_load); else passed++;
        total++; if (s.beats !== 7) $display("FAIL one_row_beats: got %0d expected 7", s.beats); else passed++;
        total++; if (s.shifts !== 9) $display("FAIL one_row_shifts: got %0d expected 9", s.shifts); else passed++;
        total++; if (s.done_at !== 21) $display("FAIL one_row_done_time: got %0d expected 21", s.done_at); else passed++;
        total++; if (s.dones !== 1) $display("FAIL one_row_done_count: got %0d expected 1", s.dones); else passed++;
        total++; if (s.busy_cyc !== 21) $display("FAIL one_row_busy_cycles: got %0d expected 21", s.busy_cyc); else passed++;
        total++; if (s.busy_after !== 0) $display("FAIL one_row_busy_after: got %0d expected 0", s.busy_after); else passed++;
        total++; if (s.seq_err !== 0) $display("FAIL one_row_sequence: got %0d errors expected 0", s.seq_err); else passed++;
        total++; if (s.col_done !== 6) $display("FAIL one_row_final_col: got %0d expected 6", s.col_done); else passed++;
        total++; if (s.sh_done !== 0) $display("FAIL one_row_final_shift: got %0d expected 0", s.sh_done); else passed++;
    endtask

    task automatic test_multi_row();
        stats_t s;
        run_job(3, 1'b0, 1'b0, s);
        total++; if (s.beats !== 21) $display("FAIL three_row_beats: got %0d expected 21", s.beats); else passed++;
        total++; if (s.shifts !== 27) $display("FAIL three_row_shifts: got %0d expected 27", s.shifts); else passed++;
        total++; if (s.loads !== 3) $display("FAIL three_row_load_phases: got %0d expected 3", s.loads); else passed++;
        total++; if (s.done_at !== 53) $display("FAIL three_row_done_time: got %0d expected 53", s.done_at); else passed++;
        total++; if (s.dones !== 1) $display("FAIL three_row_done_count: got %0d expected 1", s.dones); else passed++;
        total++; if (s.acc_done !== 2) $display("FAIL three_row_final_acc: got %0d expected 2", s.acc_done); else passed++;
        total++; if (s.seq_err !== 0) $display("FAIL three_row_sequence: got %0d errors expected 0", s.seq_err); else passed++;
    endtask

    task automatic test_stalls();
        stats_t s;
        run_job(2, 1'b1, 1'b0, s);
        total++; if (s.beats !== 14) $display("FAIL stall_beats: got %0d expected 14", s.beats); else passed++;
        total++; if (s.shifts !== 18) $display("FAIL stall_shifts: got %0d expected 18", s.shifts); else passed++;
        total++; if (s.dones !== 1) $display("FAIL stall_done_count: got %0d expected 1", s.dones); else passed++;
        total++; if (s.gate_err !== 0) $display("FAIL stall_gating: got %0d violations expected 0", s.gate_err); else passed++;
        total++; if (s.hold_err !== 0) $display("FAIL stall_hold: got %0d violations expected 0", s.hold_err); else passed++;
        total++; if (s.seq_err !== 0) $display("FAIL stall_sequence: got %0d errors expected 0", s.seq_err); else passed++;
    endtask

    task automatic test_abort();
        bit found;
        int dones;
        logic [19:0] cnts;
        found = 1'b0; dones = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_rows = 8'd3; bus.in_valid = 1'b1; bus.mac_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.acc_counter == 8'd1 && bus.shift_count == 4'd4 && bus.x_shift) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (found !== 1'b1) $display("FAIL abort_reach_point: got %b expected 1 (timeout)", found); else passed++;
        bus.abort = 1'b1;
        #1;
        total++; if (bus.x_shift !== 1'b0) $display("FAIL abort_gates_shift: got %b expected 0", bus.x_shift); else passed++;
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL abort_idle: got busy %b expected 0", bus.busy); else passed++;
        cnts = {bus.col_counter, bus.shift_count, bus.acc_counter};
        total++; if (cnts !== 20'd0) $display("FAIL abort_counters: got %h expected 0", cnts); else passed++;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            if (bus.done) dones++;
        end
        total++; if (dones !== 0) $display("FAIL abort_no_done: got %0d expected 0", dones); else passed++;
        bus.in_valid = 1'b0; bus.mac_ready = 1'b0;
    endtask

    task automatic test_start_ignored();
        stats_t s;
        int busy_seen, dones;
        busy_seen = 0; dones = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_rows = 8'd0;
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_rows = 8'd2; bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.busy || bus.load_en) busy_seen++;
            if (bus.done) dones++;
            @(negedge clk);
        end
        total++; if (busy_seen !== 0) $display("FAIL zero_rows_or_abort_start: got %0d busy cycles expected 0", busy_seen); else passed++;
        total++; if (dones !== 0) $display("FAIL zero_rows_no_done: got %0d expected 0", dones); else passed++;
        run_job(2, 1'b0, 1'b1, s);
        total++; if (s.done_at !== 37) $display("FAIL midjob_start_done_time: got %0d expected 37", s.done_at); else passed++;
        total++; if (s.acc_done !== 1) $display("FAIL midjob_start_final_acc: got %0d expected 1", s.acc_done); else passed++;
        total++; if (s.beats !== 14) $display("FAIL midjob_start_beats: got %0d expected 14", s.beats); else passed++;
        total++; if (s.busy_after !== 0) $display("FAIL midjob_start_busy_after: got %0d expected 0", s.busy_after); else passed++;
    endtask

    task automatic test_reset_mid_load();
        bit found;
        logic [30:0] obs;
        stats_t s;
        found = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_rows = 8'd2; bus.in_valid = 1'b1; bus.mac_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (bus.load_en && bus.col_counter == 8'd3) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (found !== 1'b1) $display("FAIL rst_mid_reach_point: got %b expected 1 (timeout)", found); else passed++;
        rst = 1'b0;
        #1;
        obs = {bus.in_ready, bus.load_en, bus.x_shift, bus.busy, bus.done,
               bus.col_counter, bus.shift_count, bus.acc_counter, 2'b00};
        total++; if (obs !== 31'd0) $display("FAIL rst_mid_immediate: got %h expected 0", obs); else passed++;
        @(negedge clk); #1;
        obs = {bus.in_ready, bus.load_en, bus.x_shift, bus.busy, bus.done,
               bus.col_counter, bus.shift_count, bus.acc_counter, 2'b00};
        total++; if (obs !== 31'd0) $display("FAIL rst_mid_held: got %h expected 0", obs); else passed++;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.mac_ready = 1'b0;
        run_job(1, 1'b0, 1'b0, s);
        total++; if (s.done_at !== 21) $display("FAIL rst_restart_done_time: got %0d expected 21", s.done_at); else passed++;
        total++; if (s.dones !== 1) $display("FAIL rst_restart_done_count: got %0d expected 1", s.dones); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single_row();
        test_multi_row();
        test_stalls();
        test_abort();
        test_single_row();
        test_start_ignored();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
